// File: rtl/nine_key_pkg.sv
// Shared types and helpers for the 3x3 key matrix scanner.
// Key index order matches the LED segment pattern: col*3+row.
package nine_key_pkg;
    localparam int KEY_ROWS  = 3;
    localparam int KEY_COLS  = 3;
    localparam int KEY_COUNT = 9;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } scan_state_t;

    function automatic key_code_t key_index(input int col, input int row);
        return key_code_t'(col * KEY_ROWS + row);
    endfunction
endpackage

// File: rtl/key_debounce.sv
// One key's debouncer: its state flips only after DEBOUNCE_SCANS consecutive
// disagreeing samples. rise pulses for one cycle on a debounced press.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic sample,
    output logic state,
    output logic rise
);
    localparam logic [3:0] LIMIT = 4'(DEBOUNCE_SCANS);

    logic [3:0] count_reg;
    logic       state_reg;
    logic       rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            state_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            rise_reg <= 1'b0;
            if (sample_en) begin
                if (sample == state_reg) begin
                    count_reg <= '0;
                end else if (count_reg + 4'd1 >= LIMIT) begin
                    count_reg <= '0;
                    state_reg <= sample;
                    rise_reg  <= sample;
                end else begin
                    count_reg <= count_reg + 4'd1;
                end
            end
        end
    end

    assign state = state_reg;
    assign rise  = rise_reg;
endmodule

// File: rtl/nine_key_matrix_scanner.sv
// Scans a 3x3 active-low key matrix one column at a time, debounces every key
// and reports press events through a valid/ack handshake with a sticky overflow.
module nine_key_matrix_scanner
    import nine_key_pkg::*;
#(
    parameter int SCAN_DIV       = 262144,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     rows_in,
    output logic [2:0]     cols_out,
    output logic [8:0]     keys,
    output logic           key_valid,
    output key_code_t      key_code,
    input  logic           key_ack,
    output logic           overflow
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [2:0]           sync1_reg;
    logic [2:0]           rows_sync_reg;
    logic [DW-1:0]        dwell_reg;
    scan_state_t          state_reg;
    logic [2:0]           cols_reg;
    logic                 dwell_last;
    logic [KEY_COLS-1:0]  col_sel;
    logic [KEY_COUNT-1:0] key_state;
    logic [KEY_COUNT-1:0] key_rise;
    logic                 cand_valid;
    key_code_t            cand_code;
    logic                 multi_press;
    logic                 drop;
    logic                 key_valid_reg;
    key_code_t            key_code_reg;
    logic                 overflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg     <= 3'b111;
            rows_sync_reg <= 3'b111;
        end else begin
            sync1_reg     <= rows_in;
            rows_sync_reg <= sync1_reg;
        end
    end

    assign dwell_last = (dwell_reg == DWELL_LAST);

    // Rows are sampled on the last dwell cycle so the synchronizer has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_reg <= '0;
            state_reg <= COL0;
            cols_reg  <= 3'b110;
        end else if (dwell_last) begin
            dwell_reg <= '0;
            case (state_reg)
                COL0:    begin state_reg <= COL1; cols_reg <= 3'b101; end
                COL1:    begin state_reg <= COL2; cols_reg <= 3'b011; end
                default: begin state_reg <= COL0; cols_reg <= 3'b110; end
            endcase
        end else begin
            dwell_reg <= dwell_reg + DW'(1);
        end
    end

    always_comb begin
        col_sel = '0;
        case (state_reg)
            COL0:    col_sel = 3'b001;
            COL1:    col_sel = 3'b010;
            COL2:    col_sel = 3'b100;
            default: col_sel = '0;
        endcase
    end

    for (genvar gi = 0; gi < KEY_COUNT; gi++) begin : g_key
        localparam int COL = gi / KEY_ROWS;
        localparam int ROW = gi % KEY_ROWS;

        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .sample_en(dwell_last && col_sel[COL]),
            .sample   (~rows_sync_reg[ROW]),
            .state    (key_state[gi]),
            .rise     (key_rise[gi])
        );
    end

    // Lowest-index rising key wins; any additional simultaneous press is dropped.
    always_comb begin
        cand_valid = 1'b0;
        cand_code  = '0;
        for (int c = KEY_COLS - 1; c >= 0; c--) begin
            for (int r = KEY_ROWS - 1; r >= 0; r--) begin
                if (key_rise[key_index(c, r)]) begin
                    cand_valid = 1'b1;
                    cand_code  = key_index(c, r);
                end
            end
        end
        multi_press = ($countones(key_rise) > 1);
        drop        = multi_press || (cand_valid && key_valid_reg && !key_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_reg <= 1'b0;
            key_code_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (!key_valid_reg || key_ack) begin
                key_valid_reg <= cand_valid;
                if (cand_valid) begin
                    key_code_reg <= cand_code;
                end
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (key_ack && key_valid_reg) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign cols_out  = cols_reg;
    assign keys      = key_state;
    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_nine_key_matrix_scanner.sv
// Bench for the key matrix scanner: a pressed-key mask drives the rows from the
// column drives; expected press events are queued and checked by a monitor.
module tb_nine_key_matrix_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_ack = 1'b0;
    logic [2:0] rows_in;
    logic [2:0] cols_out;
    logic [8:0] keys;
    logic       key_valid;
    logic [3:0] key_code;
    logic       overflow;
    logic [8:0] pressed = '0;
    logic       mon_valid_prev = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    nine_key_matrix_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rows_in  (rows_in),
        .cols_out (cols_out),
        .keys     (keys),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ack  (key_ack),
        .overflow (overflow)
    );

    // A pressed key pulls its row low while its column is driven.
    always_comb begin
        rows_in = 3'b111;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (!cols_out[c] && pressed[c * 3 + r]) begin
                    rows_in[r] = 1'b0;
                end
            end
        end
    end

    function automatic logic [2:0] col_pat(input int c);
        logic [2:0] one;
        one = 3'b001 << c;
        return ~one;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end else begin
            $display("ok   %s: 'h%0h", name, actual);
        end
    endtask

    task automatic timeout(input string name);
        assert_count++;
        fail_count++;
        $display("FAIL %s: timed out waiting, got cols_out=%b, expected a column change", name, cols_out);
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (cols_out != col_pat(c)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                timeout("wait_col");
                return;
            end
        end
    endtask

    // Returns at the first negedge after column c's sample edge.
    task automatic wait_col_end(input int c);
        int n;
        wait_col(c);
        n = 0;
        while (cols_out == col_pat(c)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                timeout("wait_col_end");
                return;
            end
        end
    endtask

    task automatic settle();
        repeat (3) wait_col_end(0);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic check_col_sequence(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (i > 0) @(negedge clk);
            check(name, cols_out, col_pat((i / SCAN_DIV) % 3));
        end
    endtask

    // Monitor: a new event is valid rising, or valid held across an accepted ack.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mon_valid_prev = 1'b0;
            end else begin
                if (key_valid && (!mon_valid_prev || key_ack)) begin
                    if (exp_q.size() == 0) begin
                        assert_count++;
                        fail_count++;
                        $display("FAIL unexpected_event: got key_code=%0d, expected no event", key_code);
                    end else begin
                        check("event_key_code", key_code, exp_q.pop_front());
                    end
                end
                mon_valid_prev = key_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset values and column sequence
        repeat (3) @(negedge clk);
        check("rst_cols_out", cols_out, 3'b110);
        check("rst_keys", keys, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        check_col_sequence("col_sequence", 24);

        // 2: key 4 press, event, hold, ack
        wait_col(0);
        pressed = 9'h010;
        wait_col_end(1);
        check("k4_first_sample_keys", keys, 9'h000);
        wait_col_end(1);
        check("k4_debounced_keys", keys, 9'h010);
        check("k4_valid_not_yet", key_valid, 0);
        exp_q.push_back(4);
        @(negedge clk);
        check("k4_valid", key_valid, 1);
        repeat (5) @(negedge clk);
        check("k4_valid_held", key_valid, 1);
        check("k4_code_held", key_code, 4);
        ack_pulse();
        check("k4_valid_after_ack", key_valid, 0);
        pressed = '0;
        settle();
        check("k4_released_keys", keys, 9'h000);
        check("k4_no_release_event", key_valid, 0);

        // 3: one-sample glitch on key 4
        wait_col(0);
        pressed = 9'h010;
        wait_col_end(1);
        pressed = '0;
        check("glitch_keys", keys, 9'h000);
        settle();
        check("glitch_keys_later", keys, 9'h000);
        check("glitch_valid", key_valid, 0);

        // 4: key 2 pending, key 7 dropped
        wait_col(1);
        pressed = 9'h004;
        wait_col_end(0);
        wait_col_end(0);
        check("k2_keys", keys, 9'h004);
        exp_q.push_back(2);
        @(negedge clk);
        check("k2_valid", key_valid, 1);
        wait_col(1);
        pressed = 9'h084;
        wait_col_end(2);
        wait_col_end(2);
        check("k7_keys", keys, 9'h084);
        @(negedge clk);
        check("k7_code_kept", key_code, 2);
        check("k7_valid_kept", key_valid, 1);
        check("k7_overflow", overflow, 1);
        ack_pulse();
        check("k7_valid_after_ack", key_valid, 0);
        check("k7_overflow_after_ack", overflow, 0);
        pressed = '0;
        settle();
        check("k2k7_released", keys, 9'h000);

        // 5: keys 3 and 5 in the same sample
        wait_col(0);
        pressed = 9'h028;
        wait_col_end(1);
        wait_col_end(1);
        check("k35_keys", keys, 9'h028);
        exp_q.push_back(3);
        @(negedge clk);
        check("k35_valid", key_valid, 1);
        check("k35_overflow", overflow, 1);
        ack_pulse();
        check("k35_valid_after_ack", key_valid, 0);
        check("k35_overflow_after_ack", overflow, 0);
        pressed = '0;
        settle();
        check("k35_released", keys, 9'h000);

        // 6: asynchronous reset mid-dwell in COL1 with an event pending
        wait_col(1);
        pressed = 9'h002;
        wait_col_end(0);
        wait_col_end(0);
        check("k1_keys", keys, 9'h002);
        exp_q.push_back(1);
        @(negedge clk);
        check("k1_valid", key_valid, 1);
        @(negedge clk);
        check("k1_mid_dwell_col1", cols_out, 3'b101);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cols_out", cols_out, 3'b110);
        check("arst_keys", keys, 0);
        check("arst_key_valid", key_valid, 0);
        check("arst_key_code", key_code, 0);
        check("arst_overflow", overflow, 0);
        pressed = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_col_sequence("restart_sequence", 12);
        repeat (2) @(negedge clk);
        check("no_event_after_reset", key_valid, 0);

        check("pending_events_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
